// File: rtl/seq001_1007.sv
// Serial "001" sequence detector, Moore FSM with overlap.
// Exposes present/next state for debug observability.
module seq001_1007 (
   input  logic       clk,
   input  logic       reset,
   input  logic       in,
   output logic       out,
   output logic [1:0] pre_s,
   output logic [1:0] next_s
);

   typedef enum logic [1:0] {
      S0 = 2'b00,
      S1 = 2'b01,
      S2 = 2'b10,
      S3 = 2'b11
   } state_t;

   state_t state_q;
   state_t state_d;

   // Present-state register with synchronous reset to idle
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S0;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state table; S3 falls back to S1 on 0 so a shared 0 is reused
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S0: state_d = in ? S0 : S1;
         S1: state_d = in ? S0 : S2;
         S2: state_d = in ? S3 : S2;
         S3: state_d = in ? S0 : S1;
         default: state_d = S0;
      endcase
   end

   assign pre_s  = state_q;
   assign next_s = state_d;
   assign out    = (state_q == S3);

endmodule

// File: tb/tb_seq001_1007.sv
// Bench for seq001_1007: directed plan plus random bits.
// Reference tracks the received-bit suffix since the last reset.
module tb_seq001_1007;

   logic       clk = 1'b0;
   logic       reset;
   logic       in_b;
   logic       out_b;
   logic [1:0] pre_s;
   logic [1:0] next_s;

   int errs   = 0;
   int checks = 0;
   int pulses = 0;

   // suffix model: last up to 3 bits since reset, newest in bit 0
   logic [2:0] hist = '0;
   int         nbits = 0;
   bit         known = 0;

   seq001_1007 dut (
      .clk   (clk),
      .reset (reset),
      .in    (in_b),
      .out   (out_b),
      .pre_s (pre_s),
      .next_s(next_s)
   );

   always #5 clk = ~clk;

   // state implied by the longest useful suffix of the bit history
   function automatic logic [1:0] suffix_state(logic [2:0] h, int n);
      if (n >= 3 && h == 3'b001) return 2'b11;
      if (n >= 2 && h[1:0] == 2'b00) return 2'b10;
      if (n >= 1 && h[0] == 1'b0) return 2'b01;
      return 2'b00;
   endfunction

   task automatic check2(string tag, logic [1:0] obs, logic [1:0] exp);
      checks++;
      assert (obs === exp) else begin
         errs++;
         $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   task automatic check1(string tag, logic obs, logic exp);
      checks++;
      assert (obs === exp) else begin
         errs++;
         $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   // apply one bit (and reset level) across one rising edge
   task automatic step(logic b, logic r);
      logic [1:0] exp_s;
      logic [2:0] nh;
      int         nn;
      reset = r;
      in_b  = b;
      #1;
      if (known) begin
         nh = {hist[1:0], b};
         nn = (nbits < 3) ? nbits + 1 : 3;
         check2("next_s", next_s, suffix_state(nh, nn));
      end
      @(posedge clk);
      #1;
      if (r) begin
         hist  = '0;
         nbits = 0;
         known = 1;
      end else if (known) begin
         hist  = {hist[1:0], b};
         nbits = (nbits < 3) ? nbits + 1 : 3;
      end
      if (known) begin
         exp_s = suffix_state(hist, nbits);
         check2("pre_s", pre_s, exp_s);
         check1("out", out_b, exp_s == 2'b11);
      end
      if (out_b === 1'b1) pulses++;
   endtask

   task automatic run_bits(logic [15:0] bits, int len);
      logic [15:0] v;
      v = bits;
      for (int i = len - 1; i >= 0; i--) step(v[i], 1'b0);
   endtask

   initial begin
      reset = 1'b1;
      in_b  = 1'b0;

      // reset for two edges, then check state and next_s
      step(1'b0, 1'b1);
      step(1'b0, 1'b1);
      check2("rst_pre_s", pre_s, 2'b00);
      check1("rst_out", out_b, 1'b0);
      #1;
      check2("rst_next_s", next_s, 2'b01);

      // single detect then a trailing 0
      pulses = 0;
      run_bits(16'b001, 3);
      check2("single_pre_s", pre_s, 2'b11);
      check1("single_out", out_b, 1'b1);
      step(1'b0, 1'b0);
      check2("single_after", pre_s, 2'b01);
      check1("single_out_lo", out_b, 1'b0);
      check2("single_pulses", 2'(pulses), 2'd1);

      // overlap / repeat: two separate pulses
      step(1'b1, 1'b1);
      pulses = 0;
      run_bits(16'b001001, 6);
      check2("overlap_pulses", 2'(pulses), 2'd2);

      // long zero run
      step(1'b0, 1'b1);
      pulses = 0;
      run_bits(16'b00000, 5);
      check2("zrun_pre_s", pre_s, 2'b10);
      check1("zrun_out", out_b, 1'b0);
      step(1'b1, 1'b0);
      check1("zrun_out_hi", out_b, 1'b1);

      // non-matching pattern
      step(1'b0, 1'b1);
      pulses = 0;
      run_bits(16'b1101011, 7);
      check2("nomatch_pulses", 2'(pulses), 2'd0);

      // mid-sequence reset with in=1, then in=1 after release
      run_bits(16'b00, 2);
      step(1'b1, 1'b1);
      check2("midrst_pre_s", pre_s, 2'b00);
      check1("midrst_out", out_b, 1'b0);
      step(1'b1, 1'b0);
      check2("midrst_hold", pre_s, 2'b00);

      // reset while in S3 drops out
      run_bits(16'b001, 3);
      step(1'b0, 1'b1);
      check1("rst_s3_out", out_b, 1'b0);

      // random bits with occasional resets, 0-biased to hit matches
      for (int i = 0; i < 400; i++) begin
         step(($urandom_range(0, 2) == 0) ? 1'b1 : 1'b0,
              ($urandom_range(0, 39) == 0) ? 1'b1 : 1'b0);
      end

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule

// File: doc/seq001_1007.md
Name: seq001_1007

Overview:
Serial "001" sequence detector built as a Moore FSM with 2-bit state encoding. It samples one bit of `in` per rising edge of `clk`. It asserts `out` for one state period after the pattern 0,0,1 has been received; overlapping detection is supported. The present-state and next-state vectors are exported for debug and observability.

Parameters:
None. The state encoding is fixed: S0=2'b00, S1=2'b01, S2=2'b10, S3=2'b11.

Ports:
clk  input  1  system clock; all state updates occur on the rising edge
reset  input  1  synchronous, active-high reset; sampled on the rising edge of clk
in  input  1  serial data bit, sampled at each rising clk edge
out  output  1  detection flag; 1 while the present state is S3
pre_s  output  2  present-state register (registered)
next_s  output  2  next-state value (combinational function of pre_s and in)

Behaviour:
- One clock; reset is synchronous and active-high.
  - On a rising clk edge with reset=1: pre_s <= S0, regardless of in.
  - Reset has no effect between edges.
- State meanings:
  - S0: idle, no useful prefix.
  - S1: last bit was "0".
  - S2: last bits were "00".
  - S3: "001" just detected.
- Transition table, written as (state, in) -> next_s:
  - S0: in=0 -> S1; in=1 -> S0.
  - S1: in=0 -> S2; in=1 -> S0.
  - S2: in=0 -> S2 (any run of 0s keeps the "00" suffix); in=1 -> S3.
  - S3: in=0 -> S1 (overlap, new prefix "0"); in=1 -> S0.
- State register: on a rising edge with reset=0, pre_s <= next_s.
- next_s:
  - Purely combinational from pre_s and in; it updates immediately when either changes.
  - It is not forced during reset; it always reflects the table.
- out:
  - Moore output; out = (pre_s == S3).
  - Glitch-free with respect to in, and never depends on in directly.
- Latency:
  - The '1' that completes "001" is sampled at edge N.
  - out goes high after edge N and stays high until edge N+1.
  - The pulse width is exactly one clock when the following bit does not also complete a match, which is always the case because S3 never returns to S3.
- Back-to-back detection:
  - Sequence 0,0,1,0,0,1 yields two separate one-cycle out pulses.
  - A shared 0 after S3 counts toward the next match.
- Power-up:
  - Before the first reset, pre_s is unspecified (X in simulation).
  - The bench must apply reset for at least one edge before checking.
- Reset mid-sequence:
  - Any partial prefix is discarded and pre_s returns to S0.
  - If reset is asserted while pre_s=S3, out drops to 0 after that edge.
- No illegal states exist: all four encodings are defined.

Test Plan:
- Reset: reset=1, in=0 for 2 edges -> pre_s=00, out=0; next_s=01 (S0 with in=0).
- Single detect: after reset, drive in=0,0,1 on successive edges -> pre_s sequence 01,10,11; out=1 only in the cycle after the third edge, then in=0 -> pre_s=01, out=0.
- Overlap / repeat: in=0,0,1,0,0,1 -> out pulses in cycles 3 and 6 only; pre_s=11 in exactly those cycles.
- Long zero run: in=0,0,0,0,0,1 -> pre_s stays 10 from the 2nd edge through the 5th; out=1 only after the 6th edge.
- Non-matching: in=1,1,0,1,0,1,1 -> out never asserts; pre_s never reaches 11.
- Mid-sequence reset: in=0,0 then reset=1 with in=1 on the next edge -> pre_s=00, out=0; after release, in=1 -> pre_s stays 00.
